div_unit: RTL and testbench

//   Multi-cycle RV64M divide/remainder unit in the EX stage, next to the ALU.
//   The ALU keeps its single-cycle ops (add..mulh, slt, sltu).
//   DIV/DIVU/REM/REMU are issued here with a start/busy/done handshake.
//   The pipeline stalls on busy.

---
 rtl/div_unit.sv | 195 +++++++++++++++++++
 tb/tb_div_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV64M DIV/DIVU/REM/REMU unit.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, with the sign fix-up folded into the last iteration so that the
// result register is written exactly once per operation.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_IDLE | no operation in flight; start is sampled
//   S_CALC | iterating, one quotient bit per cycle; busy=1
//   S_DONE | result valid, done=1 for this single cycle; start is sampled
//
// Divide-by-zero and signed overflow are resolved at accept and go straight
// to S_DONE without iterating.
module div_unit #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_INIT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    generate
        if (XLEN < 2) begin : g_bad_xlen
            $error("div_unit: XLEN must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    logic            w_accept;
    logic            w_finish;

    // operand decode at accept
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    // one restoring step
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_rem_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_it;
    logic [XLEN-1:0] w_quo_it;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_final;

    // Decode the incoming request: magnitudes, signs and the two cases that
    // need no iteration. INT_MIN negates to itself, which is the correct
    // unsigned magnitude 2^(XLEN-1).
    always_comb begin
        w_signed      = ~op[0];
        w_a_neg       = w_signed & a[XLEN-1];
        w_b_neg       = w_signed & b[XLEN-1];
        w_a_mag       = w_a_neg ? (~a + 1'b1) : a;
        w_b_mag       = w_b_neg ? (~b + 1'b1) : b;
        w_b_zero      = (b == '0);
        w_ovf         = w_signed & (a == INT_MIN) & (&b);
        w_special     = w_b_zero | w_ovf;
        w_special_res = '0;
        if (w_b_zero) begin
            w_special_res = op[1] ? a : '1;
        end else begin
            w_special_res = op[1] ? '0 : a;
        end
    end

    // One iteration: shift the next dividend bit into the partial remainder,
    // trial-subtract the divisor and keep the difference when no borrow.
    // The partial remainder is always below the divisor, so the shifted
    // value needs one extra bit but the kept remainder fits in XLEN bits.
    always_comb begin
        w_rem_sh   = {r_rem, r_quo[XLEN-1]};
        w_rem_diff = w_rem_sh - {1'b0, r_div};
        w_ge       = ~w_rem_diff[XLEN];
        w_rem_it   = w_ge ? w_rem_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        w_quo_it   = {r_quo[XLEN-2:0], w_ge};
        w_quo_fix  = r_neg_q ? (~w_quo_it + 1'b1) : w_quo_it;
        w_rem_fix  = r_neg_r ? (~w_rem_it + 1'b1) : w_rem_it;
        w_final    = r_is_rem ? w_rem_fix : w_quo_fix;
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; kill overrides a simultaneous start.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !kill) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (kill) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start && !kill) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_special ? S_DONE : S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, iterate in CALC, write result on entering DONE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            r_div    <= w_b_mag;
            r_cnt    <= CNT_INIT;
            r_is_rem <= op[1];
            r_neg_q  <= ~op[1] & (w_a_neg ^ w_b_neg);
            r_neg_r  <= op[1] & w_a_neg;
            if (w_special) begin
                r_result <= w_special_res;
            end
        end else if (r_state == S_CALC && !kill) begin
            r_quo <= w_quo_it;
            r_rem <= w_rem_it;
            r_cnt <= r_cnt - 1'b1;
            if (w_finish) begin
                r_result <= w_final;
            end
        end
    end

    assign result = r_result;
    assign busy   = (r_state == S_CALC);
    assign done   = (r_state == S_DONE);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed tests for div_unit with a cycle-level reference model
// computed from plain arithmetic and a per-cycle compare process.
module tb_div_unit;

    localparam int XLEN = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    logic        CLK;
    logic        RESET;
    logic        start;
    logic        kill;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] result;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    div_unit #(.XLEN(XLEN)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference arithmetic straight from the RV64M rules.
    function automatic logic [63:0] m_calc(input logic [1:0] mop, input logic [63:0] ma,
                                           input logic [63:0] mb, output bit special);
        longint sa;
        longint sb;
        sa = longint'(ma);
        sb = longint'(mb);
        special = 1'b0;
        if (mb == 64'd0) begin
            special = 1'b1;
            return mop[1] ? ma : ONES;
        end
        if (!mop[0] && ma == MINV && mb == ONES) begin
            special = 1'b1;
            return mop[1] ? 64'd0 : ma;
        end
        case (mop)
            2'b00:   return 64'(sa / sb);
            2'b01:   return ma / mb;
            2'b10:   return 64'(sa % sb);
            default: return ma % mb;
        endcase
    endfunction

    // Cycle model: remaining-cycle countdown while an op is outstanding.
    bit          m_live = 1'b0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_pend = '0;
    int          m_left = 0;

    always @(posedge CLK) begin
        bit          sp;
        logic [63:0] ev;
        if (RESET) begin
            m_live = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = '0;
            m_left = 0;
        end else if (m_busy) begin
            m_done = 1'b0;
            if (kill) begin
                m_busy = 1'b0;
            end else if (m_left == 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_res  = m_pend;
            end else begin
                m_left--;
            end
        end else begin
            m_done = 1'b0;
            if (start && !kill) begin
                ev = m_calc(op, a, b, sp);
                if (sp) begin
                    m_done = 1'b1;
                    m_res  = ev;
                end else begin
                    m_busy = 1'b1;
                    m_left = XLEN;
                    m_pend = ev;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (m_live) begin
            chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
            chk("cyc_done", {63'd0, done}, {63'd0, m_done});
            chk("cyc_result", result, m_res);
            chk("cyc_excl", {63'd0, busy & done}, 64'd0);
        end
    end

    // Called at a negedge: present the request for one edge.
    task automatic issue(input logic [1:0] iop, input logic [63:0] ia, input logic [63:0] ib);
        op    = iop;
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    // Counts edges since accept until done is seen; bounded.
    task automatic wait_done(input int lat0, output int lat, output int bcnt);
        lat  = lat0;
        bcnt = 0;
        while (!done && lat < 200) begin
            if (busy) bcnt++;
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] iop, input logic [63:0] ia,
                          input logic [63:0] ib, input logic [63:0] exp, input int exp_lat);
        int lat;
        int bc;
        issue(iop, ia, ib);
        wait_done(1, lat, bc);
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_busycyc"}, 64'(bc), 64'(exp_lat - 1));
        chk({nm, "_res"}, result, exp);
    endtask

    initial begin
        int lat;
        int bc;
        int dcnt;
        RESET = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        chk("rst_result", result, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);

        run_op("divu_66_11", 2'b01, 64'd66, 64'd11, 64'd6, 65);
        run_op("rem_m62_3", 2'b10, -64'sd62, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);

        // DIV -7/2 with a stray start pulse during CALC
        issue(2'b00, -64'sd7, 64'd2);
        repeat (3) @(negedge CLK);
        issue(2'b01, 64'd100, 64'd7);
        wait_done(5, lat, bc);
        chk("div_m7_2_lat", 64'(lat), 64'd65);
        chk("div_m7_2_res", result, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("div_5_0", 2'b00, 64'd5, 64'd0, ONES, 1);
        run_op("remu_5_0", 2'b11, 64'd5, 64'd0, 64'd5, 1);
        run_op("div_ovf", 2'b00, MINV, ONES, MINV, 1);

        // kill mid-CALC: no done, result unchanged
        issue(2'b01, 64'd1000, 64'd7);
        repeat (8) @(negedge CLK);
        kill = 1'b1;
        @(negedge CLK);
        kill = 1'b0;
        chk("kill_busy", {63'd0, busy}, 64'd0);
        chk("kill_done", {63'd0, done}, 64'd0);
        chk("kill_res", result, MINV);
        dcnt = 0;
        repeat (70) begin
            @(negedge CLK);
            if (done) dcnt++;
        end
        chk("kill_nodone", 64'(dcnt), 64'd0);

        run_op("remu_62_3", 2'b11, 64'd62, 64'd3, 64'd2, 65);
        run_op("rem_ovf", 2'b10, MINV, ONES, 64'd0, 1);

        // back-to-back: second start presented during the DONE cycle
        issue(2'b00, 64'd100, -64'sd7);
        wait_done(1, lat, bc);
        chk("b2b_first_res", result, 64'hFFFF_FFFF_FFFF_FFF2);
        issue(2'b11, 64'd100, 64'd9);
        wait_done(1, lat, bc);
        chk("b2b_second_lat", 64'(lat), 64'd65);
        chk("b2b_second_res", result, 64'd1);

        // start and kill together in DONE: nothing accepted
        issue(2'b00, 64'd5, 64'd0);
        wait_done(1, lat, bc);
        chk("dk_done_seen", {63'd0, done}, 64'd1);
        start = 1'b1;
        kill  = 1'b1;
        op    = 2'b01;
        a     = 64'd9;
        b     = 64'd3;
        @(negedge CLK);
        start = 1'b0;
        kill  = 1'b0;
        chk("dk_busy", {63'd0, busy}, 64'd0);
        chk("dk_done", {63'd0, done}, 64'd0);
        chk("dk_res", result, ONES);

        // reset in the middle of CALC
        issue(2'b01, 64'd66, 64'd11);
        repeat (5) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("rstmid_busy", {63'd0, busy}, 64'd0);
        chk("rstmid_done", {63'd0, done}, 64'd0);
        chk("rstmid_res", result, 64'd0);

        run_op("div_m100_m7", 2'b00, -64'sd100, -64'sd7, 64'd14, 65);
        run_op("remu_big", 2'b11, ONES, 64'd10, 64'd5, 65);

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
